// File: rtl/apu_dmc_reader_if.sv
// Signal bundle between the DMC memory reader and its CPU, DMA and output-unit neighbours.
// The slave modport is the reader's view; the master modport is the surrounding logic.

interface apu_dmc_reader_if;
  logic        ce;
  logic        reg_write;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        ctrl_write;
  logic        dmc_ack;
  logic [7:0]  data_from_ram;
  logic        buffer_take;
  logic        dmc_trigger;
  logic [15:0] dmc_dma_addr;
  logic [7:0]  sample_byte;
  logic        buffer_full;
  logic [3:0]  rate_index;
  logic        dmc_active;
  logic        irq;

  modport slave (
    input  ce,
    input  reg_write,
    input  reg_addr,
    input  reg_data,
    input  ctrl_write,
    input  dmc_ack,
    input  data_from_ram,
    input  buffer_take,
    output dmc_trigger,
    output dmc_dma_addr,
    output sample_byte,
    output buffer_full,
    output rate_index,
    output dmc_active,
    output irq
  );

  modport master (
    output ce,
    output reg_write,
    output reg_addr,
    output reg_data,
    output ctrl_write,
    output dmc_ack,
    output data_from_ram,
    output buffer_take,
    input  dmc_trigger,
    input  dmc_dma_addr,
    input  sample_byte,
    input  buffer_full,
    input  rate_index,
    input  dmc_active,
    input  irq
  );
endinterface

// File: rtl/apu_dmc_reader.sv
// APU DMC memory reader: sample address/length registers, DMA request and one-byte buffer.
// Define APU_DMC_IRQ_EN to build the DMC interrupt; otherwise irq is tied low.

module apu_dmc_reader (
  input logic             clk,
  input logic             reset,
  apu_dmc_reader_if.slave bus
);

  logic [15:0] addr_q, addr_d;
  logic [11:0] remaining_q, remaining_d;
  logic [7:0]  sample_q, sample_d;
  logic        full_q, full_d;
  logic        loop_q, loop_d;
  logic [3:0]  rate_q, rate_d;
  logic [7:0]  start_q, start_d;
  logic [7:0]  len_q, len_d;

  logic        trigger;
  logic        fetch;
  logic        last_fetch;
  logic        ctrl_en;
  logic        ctrl_dis;
  logic        restart;
  logic [15:0] start_addr;
  logic [11:0] start_len;

  assign start_addr = 16'hC000 + {2'b00, start_q, 6'b000000};
  assign start_len  = {len_q, 4'b0000} + 12'd1;

  assign trigger    = !full_q && (remaining_q != 12'd0);
  assign fetch      = bus.ce && bus.dmc_ack && trigger;
  assign last_fetch = fetch && (remaining_q == 12'd1);
  assign ctrl_en    = bus.ce && bus.ctrl_write && bus.reg_data[4];
  assign ctrl_dis   = bus.ce && bus.ctrl_write && !bus.reg_data[4];
  // An enable only restarts an idle channel; a running sample is left alone.
  assign restart    = (ctrl_en && (remaining_q == 12'd0)) || (last_fetch && loop_q);

  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    sample_d    = sample_q;
    full_d      = full_q;
    loop_d      = loop_q;
    rate_d      = rate_q;
    start_d     = start_q;
    len_d       = len_q;

    if (bus.ce && bus.buffer_take) begin
      full_d = 1'b0;
    end

    if (fetch) begin
      sample_d    = bus.data_from_ram;
      full_d      = 1'b1;
      addr_d      = (addr_q == 16'hFFFF) ? 16'h8000 : addr_q + 16'd1;
      remaining_d = remaining_q - 12'd1;
    end

    // Restart reads the pre-write start/length, so same-edge register writes apply next time.
    if (restart) begin
      addr_d      = start_addr;
      remaining_d = start_len;
    end

    if (ctrl_dis) begin
      remaining_d = 12'd0;
    end

    if (bus.ce && bus.reg_write) begin
      unique case (bus.reg_addr)
        2'd0: begin
          loop_d = bus.reg_data[6];
          rate_d = bus.reg_data[3:0];
        end
        2'd1: ;
        2'd2: start_d = bus.reg_data;
        2'd3: len_d   = bus.reg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= 16'hC000;
      remaining_q <= 12'd0;
      sample_q    <= 8'h00;
      full_q      <= 1'b0;
      loop_q      <= 1'b0;
      rate_q      <= 4'd0;
      start_q     <= 8'h00;
      len_q       <= 8'h00;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      sample_q    <= sample_d;
      full_q      <= full_d;
      loop_q      <= loop_d;
      rate_q      <= rate_d;
      start_q     <= start_d;
      len_q       <= len_d;
    end
  end

`ifdef APU_DMC_IRQ_EN
  logic irq_q, irq_d;
  logic irq_en_q, irq_en_d;
  logic irq_clear;

  assign irq_clear = bus.ce && (bus.ctrl_write ||
                     (bus.reg_write && (bus.reg_addr == 2'd0) && !bus.reg_data[7]));

  always_comb begin
    irq_d    = irq_q;
    irq_en_d = irq_en_q;
    if (bus.ce && bus.reg_write && (bus.reg_addr == 2'd0)) begin
      irq_en_d = bus.reg_data[7];
    end
    if (last_fetch && !loop_q && irq_en_q) begin
      irq_d = 1'b1;
    end
    // Clear wins over a same-edge set.
    if (irq_clear) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.dmc_trigger  = trigger;
  assign bus.dmc_dma_addr = addr_q;
  assign bus.sample_byte  = sample_q;
  assign bus.buffer_full  = full_q;
  assign bus.rate_index   = rate_q;
  assign bus.dmc_active   = (remaining_q != 12'd0);

endmodule

// File: tb/tb_apu_dmc_reader.sv
// Directed bench for apu_dmc_reader: vector table plus hand-written multi-cycle sequences.

module tb_apu_dmc_reader;

`ifdef APU_DMC_IRQ_EN
  localparam logic IrqOn = 1'b1;
`else
  localparam logic IrqOn = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  apu_dmc_reader_if bus ();

  apu_dmc_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        rw;
    logic [1:0]  ra;
    logic        cw;
    logic [7:0]  d;
    logic        ack;
    logic [7:0]  rd;
    logic        take;
    logic        e_trig;
    logic [15:0] e_addr;
    logic [7:0]  e_samp;
    logic        e_full;
    logic        e_act;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.ce            = 1'b1;
    bus.reg_write     = 1'b0;
    bus.reg_addr      = 2'd0;
    bus.reg_data      = 8'h00;
    bus.ctrl_write    = 1'b0;
    bus.dmc_ack       = 1'b0;
    bus.data_from_ram = 8'h00;
    bus.buffer_take   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.reg_write = 1'b1;
    bus.reg_addr  = a;
    bus.reg_data  = d;
    tick();
    idle();
  endtask

  task automatic ctrl(input logic [7:0] d);
    bus.ctrl_write = 1'b1;
    bus.reg_data   = d;
    tick();
    idle();
  endtask

  task automatic ack(input logic [7:0] d);
    bus.dmc_ack       = 1'b1;
    bus.data_from_ram = d;
    tick();
    idle();
  endtask

  task automatic take();
    bus.buffer_take = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    tick();

    chk("rst_trig", 16'(bus.dmc_trigger), 16'd0);
    chk("rst_addr", bus.dmc_dma_addr, 16'hC000);
    chk("rst_samp", 16'(bus.sample_byte), 16'h0000);
    chk("rst_full", 16'(bus.buffer_full), 16'd0);
    chk("rst_act", 16'(bus.dmc_active), 16'd0);
    chk("rst_irq", 16'(bus.irq), 16'd0);
    chk("rst_rate", 16'(bus.rate_index), 16'd0);

    //          ce    rw    ra    cw    d      ack   rd     take  trig  addr      samp   full  act
    tbl[0]  = '{1'b1, 1'b1, 2'd2, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 16'hC040, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 16'hC041, 8'h5A, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'hC041, 8'h5A, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0, 16'hC041, 8'h5A, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'hC041, 8'h5A, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 2'd3, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 16'hC041, 8'h5A, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 16'hC000, 8'h5A, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0, 16'hC001, 8'h11, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 16'hC001, 8'h11, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 16'hC001, 8'h11, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b1, 16'hC001, 8'h11, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 16'hC001, 8'h11, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'hC001, 8'h11, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 2'd0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 16'hC000, 8'h11, 1'b0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      bus.ce            = tbl[i].ce;
      bus.reg_write     = tbl[i].rw;
      bus.reg_addr      = tbl[i].ra;
      bus.ctrl_write    = tbl[i].cw;
      bus.reg_data      = tbl[i].d;
      bus.dmc_ack       = tbl[i].ack;
      bus.data_from_ram = tbl[i].rd;
      bus.buffer_take   = tbl[i].take;
      tick();
      idle();
      chk($sformatf("v%0d_trig", i), 16'(bus.dmc_trigger), 16'(tbl[i].e_trig));
      chk($sformatf("v%0d_addr", i), bus.dmc_dma_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_samp", i), 16'(bus.sample_byte), 16'(tbl[i].e_samp));
      chk($sformatf("v%0d_full", i), 16'(bus.buffer_full), 16'(tbl[i].e_full));
      chk($sformatf("v%0d_act", i), 16'(bus.dmc_active), 16'(tbl[i].e_act));
      chk($sformatf("v%0d_irq", i), 16'(bus.irq), 16'd0);
    end

    // 17-byte sample with irq enabled.
    do_reset();
    wr(2'd0, 8'h8F);
    chk("rate", 16'(bus.rate_index), 16'h000F);
    wr(2'd3, 8'h01);
    ctrl(8'h10);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("run%0d_trig", i), 16'(bus.dmc_trigger), 16'd1);
      chk($sformatf("run%0d_addr", i), bus.dmc_dma_addr, 16'hC000 + 16'(i));
      ack(8'(i + 8'h40));
      chk($sformatf("run%0d_samp", i), 16'(bus.sample_byte), 16'(i + 8'h40));
      if (i < 16) begin
        chk($sformatf("run%0d_act", i), 16'(bus.dmc_active), 16'd1);
        chk($sformatf("run%0d_irq", i), 16'(bus.irq), 16'd0);
      end
      take();
    end
    chk("run_end_act", 16'(bus.dmc_active), 16'd0);
    chk("run_end_irq", 16'(bus.irq), 16'(IrqOn));
    chk("run_end_trig", 16'(bus.dmc_trigger), 16'd0);
    ctrl(8'h00);
    chk("irq_cleared", 16'(bus.irq), 16'd0);

    // Loop mode: one-byte sample keeps restarting, never interrupts.
    do_reset();
    wr(2'd0, 8'h40);
    wr(2'd3, 8'h00);
    ctrl(8'h10);
    for (int i = 0; i < 3; i++) begin
      ack(8'hA0);
      chk($sformatf("loop%0d_addr", i), bus.dmc_dma_addr, 16'hC000);
      chk($sformatf("loop%0d_act", i), 16'(bus.dmc_active), 16'd1);
      chk($sformatf("loop%0d_irq", i), 16'(bus.irq), 16'd0);
      take();
      chk($sformatf("loop%0d_trig", i), 16'(bus.dmc_trigger), 16'd1);
    end

    // Address wrap FFFF -> 8000.
    do_reset();
    wr(2'd2, 8'hFF);
    wr(2'd3, 8'hFF);
    ctrl(8'h10);
    chk("wrap_start", bus.dmc_dma_addr, 16'hFFC0);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("wrap_ffff", bus.dmc_dma_addr, 16'hFFFF);
      ack(8'h01);
      take();
    end
    chk("wrap_addr", bus.dmc_dma_addr, 16'h8000);
    chk("wrap_act", 16'(bus.dmc_active), 16'd1);

    // Disable on the same edge as a fetch.
    do_reset();
    wr(2'd3, 8'h01);
    ctrl(8'h10);
    bus.ctrl_write    = 1'b1;
    bus.reg_data      = 8'h00;
    bus.dmc_ack       = 1'b1;
    bus.data_from_ram = 8'h77;
    tick();
    idle();
    chk("dis_samp", 16'(bus.sample_byte), 16'h0077);
    chk("dis_full", 16'(bus.buffer_full), 16'd1);
    chk("dis_act", 16'(bus.dmc_active), 16'd0);
    take();
    chk("dis_trig", 16'(bus.dmc_trigger), 16'd0);
    chk("dis_full2", 16'(bus.buffer_full), 16'd0);

    // Asynchronous reset between trigger and ack.
    do_reset();
    wr(2'd2, 8'h02);
    ctrl(8'h10);
    chk("pre_rst_trig", 16'(bus.dmc_trigger), 16'd1);
    chk("pre_rst_addr", bus.dmc_dma_addr, 16'hC080);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_trig", 16'(bus.dmc_trigger), 16'd0);
    chk("arst_addr", bus.dmc_dma_addr, 16'hC000);
    chk("arst_act", 16'(bus.dmc_active), 16'd0);
    tick();
    reset = 1'b0;
    ack(8'hEE);
    chk("arst_samp", 16'(bus.sample_byte), 16'h0000);
    chk("arst_full", 16'(bus.buffer_full), 16'd0);
    chk("arst_trig2", 16'(bus.dmc_trigger), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
